// File: rtl/nn_acc_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the
// accumulate-and-requantize stage and its rounding/saturation helper.
package nn_acc_pkg;

    localparam int PROD_W  = 67;
    localparam int ACC_W   = 76;
    localparam int BIAS_W  = 32;
    localparam int OUT_W   = 16;
    localparam int LEN_W   = 10;
    localparam int SHIFT_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

endpackage

// File: rtl/nn_rnd_sat.sv
// Round-half-up arithmetic right shift followed by signed saturation.
// Purely combinational so it can be shared with the pooling stage.
module nn_rnd_sat
    import nn_acc_pkg::*;
(
    input  logic [ACC_W-1:0]   i_acc,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [OUT_W-1:0]   o_data,
    output logic               o_sat
);

    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_half;
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_r;
    logic signed [ACC_W:0] w_max;
    logic signed [ACC_W:0] w_min;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        w_ext = {i_acc[ACC_W-1], i_acc};
        w_max = {{(ACC_W+1-OUT_W){1'b0}}, SAT_MAX};
        w_min = {{(ACC_W+1-OUT_W){1'b1}}, SAT_MIN};
        if (i_shift == {SHIFT_W{1'b0}}) begin
            w_half = {(ACC_W+1){1'b0}};
        end else begin
            w_half = {{ACC_W{1'b0}}, 1'b1} << (i_shift - {{(SHIFT_W-1){1'b0}}, 1'b1});
        end
        w_sum = w_ext + w_half;
        w_r   = w_sum >>> i_shift;
        if (w_r > w_max) begin
            o_data = SAT_MAX;
            o_sat  = 1'b1;
        end else if (w_r < w_min) begin
            o_data = SAT_MIN;
            o_sat  = 1'b1;
        end else begin
            o_data = w_r[OUT_W-1:0];
            o_sat  = 1'b0;
        end
    end

endmodule

// File: rtl/nn_acc_requant.sv
// Accumulates cfg_len signed products plus a bias, then rounds, shifts and
// saturates the sum into one activation delivered over valid/ready.
module nn_acc_requant
    import nn_acc_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [BIAS_W-1:0]  cfg_bias,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat,
    output logic               busy
);

    state_t               r_state;
    state_t               w_next;
    logic [LEN_W-1:0]     r_len;
    logic [SHIFT_W-1:0]   r_shift;
    logic [LEN_W-1:0]     r_cnt;
    logic [ACC_W-1:0]     r_acc;
    logic [OUT_W-1:0]     r_out_data;
    logic                 r_out_sat;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 w_beat;
    logic                 w_last;
    logic [OUT_W-1:0]     w_rs_data;
    logic                 w_rs_sat;

    nn_rnd_sat u_rnd_sat (
        .i_acc   (r_acc),
        .i_shift (r_shift),
        .o_data  (w_rs_data),
        .o_sat   (w_rs_sat)
    );

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        w_next = r_state;
        w_beat = in_valid && r_in_ready;
        w_last = (r_cnt == (r_len - {{(LEN_W-1){1'b0}}, 1'b1}));
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (cfg_len == {LEN_W{1'b0}}) begin
                        w_next = ROUND;
                    end else begin
                        w_next = ACC;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            ACC: begin
                if (w_beat && w_last) begin
                    w_next = ROUND;
                end else begin
                    w_next = ACC;
                end
            end
            ROUND: w_next = OUT;
            OUT: begin
                if (out_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = OUT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register and handshake/status flags, registered from the next state.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == ACC);
            r_out_valid <= (w_next == OUT);
            r_busy      <= (w_next != IDLE);
        end
    end

    // Config capture, accumulation and result registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_len      <= {LEN_W{1'b0}};
            r_shift    <= {SHIFT_W{1'b0}};
            r_cnt      <= {LEN_W{1'b0}};
            r_acc      <= {ACC_W{1'b0}};
            r_out_data <= {OUT_W{1'b0}};
            r_out_sat  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len   <= cfg_len;
                        r_shift <= cfg_shift;
                        r_cnt   <= {LEN_W{1'b0}};
                        r_acc   <= {{(ACC_W-BIAS_W){cfg_bias[BIAS_W-1]}}, cfg_bias};
                    end
                end
                ACC: begin
                    if (w_beat) begin
                        r_acc <= r_acc + {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
                        r_cnt <= r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
                ROUND: begin
                    r_out_data <= w_rs_data;
                    r_out_sat  <= w_rs_sat;
                end
                OUT: begin
                    r_out_data <= r_out_data;
                end
                default: begin
                    r_cnt <= {LEN_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign busy      = r_busy;

endmodule

// File: tb/tb_nn_acc_requant.sv
// Directed plus randomized bench for nn_acc_requant with an arithmetic
// reference model of the round/shift/saturate rules.
module tb_nn_acc_requant;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          start = 1'b0;
    logic [9:0]    cfg_len = 10'd0;
    logic [6:0]    cfg_shift = 7'd0;
    logic [31:0]   cfg_bias = 32'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [66:0]   in_data = 67'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   out_data;
    logic          out_sat;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic signed [66:0] p_arr [0:15];
    logic signed [63:0] t_rand;
    int                 r_len;
    int                 r_shift;

    nn_acc_requant dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .cfg_bias  (cfg_bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    // Reference: exact integer sum, add half an LSB, floor-divide by 2^shift, clip.
    function automatic void model(input int len, input int shift, input logic signed [31:0] bias,
                                  output logic [15:0] d, output logic s);
        logic signed [127:0] sum;
        logic signed [127:0] half;
        logic signed [127:0] r;
        sum = bias;
        for (int k = 0; k < len; k++) sum = sum + p_arr[k];
        half = 128'sd1;
        if (shift > 0) sum = sum + (half <<< (shift - 1));
        r = sum >>> shift;
        if (r > 128'sd32767) begin
            d = 16'h7fff; s = 1'b1;
        end else if (r < -128'sd32768) begin
            d = 16'h8000; s = 1'b1;
        end else begin
            d = r[15:0]; s = 1'b0;
        end
    endfunction

    task automatic run_window(input int len, input int shift, input logic signed [31:0] bias,
                              input bit gaps, input bit extra_start, input int hold);
        logic [15:0] ed;
        logic        es;
        logic        rdy;
        int          i;
        int          guard;
        model(len, shift, bias, ed, es);
        cfg_len   = len[9:0];
        cfg_shift = shift[6:0];
        cfg_bias  = bias;
        out_ready = (hold == 0);
        start     = 1'b1;
        tick;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("in_ready_after_start", in_ready, (len > 0));
        i = 0;
        guard = 0;
        while (i < len && guard < 200) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = p_arr[i];
            end
            if (extra_start && guard == 1) begin
                start = 1'b1; cfg_len = 10'd1; cfg_shift = 7'd5; cfg_bias = 32'd12345;
            end else begin
                start = 1'b0;
            end
            rdy = in_ready;
            tick;
            if (in_valid && rdy) i++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (i < len) begin
            check("accept_timeout", i, len);
            ap_rst_n = 1'b0;
            #2;
            ap_rst_n = 1'b1;
            return;
        end
        check("out_valid_in_round", out_valid, 1'b0);
        check("in_ready_in_round", in_ready, 1'b0);
        tick;
        check("out_valid_latency", out_valid, 1'b1);
        check("out_data", out_data, ed);
        check("out_sat", out_sat, es);
        for (int k = 0; k < hold; k++) begin
            tick;
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, ed);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick;
        check("out_valid_after_hs", out_valid, 1'b0);
        check("busy_after_hs", busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'd0);
        check("rst_out_sat", out_sat, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick;

        // Basic sum
        p_arr[0] = 67'sd5; p_arr[1] = -67'sd2; p_arr[2] = 67'sd7;
        run_window(3, 0, 32'sd10, 1'b0, 1'b0, 0);

        // Round half up
        p_arr[0] = 67'sd6;  run_window(1, 2, 32'sd0, 1'b0, 1'b0, 0);
        p_arr[0] = -67'sd6; run_window(1, 2, 32'sd0, 1'b0, 1'b0, 0);
        p_arr[0] = -67'sd5; run_window(1, 2, 32'sd0, 1'b0, 1'b0, 0);

        // Saturation both ways
        p_arr[0] = 67'sd1 <<< 40; p_arr[1] = 67'sd1 <<< 40;
        run_window(2, 0, 32'sd0, 1'b0, 1'b0, 0);
        p_arr[0] = -(67'sd1 <<< 40); p_arr[1] = -(67'sd1 <<< 40);
        run_window(2, 0, 32'sd0, 1'b0, 1'b0, 0);

        // Empty window under backpressure
        run_window(0, 0, -32'sd7, 1'b0, 1'b0, 5);

        // Stalls with a stray start during accumulation
        p_arr[0] = 67'sd100; p_arr[1] = -67'sd30; p_arr[2] = 67'sd1000; p_arr[3] = 67'sd4;
        run_window(4, 1, -32'sd50, 1'b1, 1'b1, 0);

        // Reset after two of four beats
        cfg_len = 10'd4; cfg_shift = 7'd0; cfg_bias = 32'd1000; start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_data = 67'd500;
        tick;
        tick;
        in_valid = 1'b0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 16'd0);
        check("midrst_out_sat", out_sat, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick;
        p_arr[0] = 67'sd9;
        run_window(1, 0, 32'sd0, 1'b0, 1'b0, 0);

        // Randomized windows
        for (int w = 0; w < 14; w++) begin
            r_len = (w == 5) ? 0 : $urandom_range(1, 8);
            r_shift = (w % 2 == 1) ? $urandom_range(0, 12) : $urandom_range(30, 75);
            for (int j = 0; j < 16; j++) begin
                t_rand = {$urandom, $urandom};
                t_rand = t_rand >>> $urandom_range(0, 56);
                p_arr[j] = t_rand;
            end
            run_window(r_len, r_shift, $urandom, ($urandom_range(0, 1) == 1), 1'b0, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
